// File: rtl/blake2s_round_sched.sv
// Purpose : iterative BLAKE2s round engine, one shared G applied to the 16-word vector per cycle.
// Latency : done pulses 8*NUM_ROUNDS edges after the start edge; one G op per cycle, no overlap.
// Backpr. : start is honoured only while ready=1; starts while busy are dropped, never queued.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a compression (sampled only when ready=1)
//   v_in, m_in   : working vector and message block, word i at [511-32i -: 32]
//   ready        : idle, next start will be accepted
//   done         : one-cycle pulse, v_out holds the new vector
//   v_out        : vector after NUM_ROUNDS rounds, held until the next completion

module blake2s_g (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m0,
  input  logic [31:0] m1,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);
  logic [31:0] a1, b1, c1, d1, dx1, bx1, dx2, bx2;

  // Rotations are right-rotates by 16, 12, 8 and 7.
  always_comb begin
    a1    = a + b + m0;
    dx1   = d ^ a1;
    d1    = {dx1[15:0], dx1[31:16]};
    c1    = c + d1;
    bx1   = b ^ c1;
    b1    = {bx1[11:0], bx1[31:12]};
    a_new = a1 + b1 + m1;
    dx2   = d1 ^ a_new;
    d_new = {dx2[7:0], dx2[31:8]};
    c_new = c1 + d_new;
    bx2   = b1 ^ c_new;
    b_new = {bx2[6:0], bx2[31:7]};
  end
endmodule

module blake2s_round_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] v_in,
  input  logic [511:0] m_in,
  output logic         ready,
  output logic         done,
  output logic [511:0] v_out
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUND = 1'b1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  logic [0:0]   state;
  logic [3:0]   round;
  logic [2:0]   g_idx;
  logic [511:0] v_reg, m_reg, v_next;

  logic [31:0]  v_w [16];
  logic [31:0]  m_w [16];
  logic [31:0]  v_nw [16];
  logic [63:0]  sigma_row, sigma_sh;
  logic [3:0]   m0_idx, m1_idx;
  logic [3:0]   ia, ib, ic, id;
  logic [31:0]  g_a, g_b, g_c, g_d;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      v_w[i] = v_reg[511-32*i -: 32];
      m_w[i] = m_reg[511-32*i -: 32];
    end
  end

  // Sigma ROM: entry j of the row is nibble j counted from the MSB.
  // Rows past 9 are unreachable and fall back to row 0.
  always_comb begin
    case (round)
      4'd0:    sigma_row = 64'h0123456789abcdef;
      4'd1:    sigma_row = 64'hea489fd61c02b753;
      4'd2:    sigma_row = 64'hb8c052fdae367194;
      4'd3:    sigma_row = 64'h7931dcbe265a40f8;
      4'd4:    sigma_row = 64'h905724afe1bc683d;
      4'd5:    sigma_row = 64'h2c6a0b834d75fe19;
      4'd6:    sigma_row = 64'hc51fed4a0763928b;
      4'd7:    sigma_row = 64'hdb7ec13950f4862a;
      4'd8:    sigma_row = 64'h6fe9b308c2d714a5;
      4'd9:    sigma_row = 64'ha2847615fb9e3cd0;
      default: sigma_row = 64'h0123456789abcdef;
    endcase
  end

  // G op k consumes sigma entries 2k and 2k+1: shift the pair to the top.
  always_comb begin
    sigma_sh = sigma_row << {g_idx, 3'b000};
    m0_idx   = sigma_sh[63:60];
    m1_idx   = sigma_sh[59:56];
  end

  // Ops 0-3 work on columns, 4-7 on diagonals.
  always_comb begin
    case (g_idx)
      3'd0:    begin ia = 4'd0; ib = 4'd4; ic = 4'd8;  id = 4'd12; end
      3'd1:    begin ia = 4'd1; ib = 4'd5; ic = 4'd9;  id = 4'd13; end
      3'd2:    begin ia = 4'd2; ib = 4'd6; ic = 4'd10; id = 4'd14; end
      3'd3:    begin ia = 4'd3; ib = 4'd7; ic = 4'd11; id = 4'd15; end
      3'd4:    begin ia = 4'd0; ib = 4'd5; ic = 4'd10; id = 4'd15; end
      3'd5:    begin ia = 4'd1; ib = 4'd6; ic = 4'd11; id = 4'd12; end
      3'd6:    begin ia = 4'd2; ib = 4'd7; ic = 4'd8;  id = 4'd13; end
      default: begin ia = 4'd3; ib = 4'd4; ic = 4'd9;  id = 4'd14; end
    endcase
  end

  blake2s_g u_g (
    .a     (v_w[ia]),
    .b     (v_w[ib]),
    .c     (v_w[ic]),
    .d     (v_w[id]),
    .m0    (m_w[m0_idx]),
    .m1    (m_w[m1_idx]),
    .a_new (g_a),
    .b_new (g_b),
    .c_new (g_c),
    .d_new (g_d)
  );

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      v_nw[i] = v_w[i];
    end
    v_nw[ia] = g_a;
    v_nw[ib] = g_b;
    v_nw[ic] = g_c;
    v_nw[id] = g_d;
    v_next = '0;
    for (int i = 0; i < 16; i++) begin
      v_next[511-32*i -: 32] = v_nw[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      round <= 4'd0;
      g_idx <= 3'd0;
      v_reg <= '0;
      m_reg <= '0;
      v_out <= '0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            v_reg <= v_in;
            m_reg <= m_in;
            round <= 4'd0;
            g_idx <= 3'd0;
            state <= ROUND;
            ready <= 1'b0;
          end
        end
        default: begin
          v_reg <= v_next;
          g_idx <= g_idx + 3'd1;
          if (g_idx == 3'd7) begin
            if (round == LAST_ROUND) begin
              // Final op: publish the updated vector the same edge it is written.
              round <= 4'd0;
              state <= IDLE;
              ready <= 1'b1;
              done  <= 1'b1;
              v_out <= v_next;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
      endcase
    end
  end
endmodule
